// File: rtl/dsp_mult_issue_collect.sv
// dsp_mult_issue_collect: issue side and collect side for a DSP38 multiplier
// that has registered inputs and registered outputs. Operand pairs go straight
// to the DSP. A valid shift pipeline tags the fired cycles. Tagged products are
// captured into a small result FIFO. Credits bound the number of products in
// flight plus buffered to FIFO_DEPTH, so a stalled consumer can never cause a
// product to be dropped.
`timescale 1ns/1ps

module dsp_mult_issue_collect #(
  parameter int DSP_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        lreset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [19:0] s_a,
  input  logic [17:0] s_b,
  input  logic        s_unsigned_a,
  input  logic        s_unsigned_b,
  output logic [19:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic        dsp_unsigned_a,
  output logic        dsp_unsigned_b,
  output logic [2:0]  dsp_feedback,
  output logic        dsp_reset,
  input  logic [37:0] dsp_z,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [37:0] m_z,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DSP_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [CNT_W-1:0]       credits_q, credits_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [37:0]            mem_q [FIFO_DEPTH];
  logic [37:0]            mem_d [FIFO_DEPTH];
  logic                   dsp_reset_q, dsp_reset_d;

  logic s_fire;
  logic m_fire;
  logic wr_en;

  // The DSP input register samples these every edge, so they are plain wires.
  // The feedback selector is tied off.
  assign dsp_a          = s_a;
  assign dsp_b          = s_b;
  assign dsp_unsigned_a = s_unsigned_a;
  assign dsp_unsigned_b = s_unsigned_b;
  assign dsp_feedback   = 3'b000;
  assign dsp_reset      = dsp_reset_q;

  // s_ready depends only on registered state, so m_ready never reaches it combinationally.
  assign s_ready = (credits_q != '0) & ~dsp_reset_q;
  assign s_fire  = s_valid & s_ready;
  assign m_valid = (count_q != '0);
  assign m_fire  = m_valid & m_ready;
  assign m_z     = mem_q[rd_ptr_q];
  assign busy    = (credits_q != DEPTH_C);
  assign wr_en   = vpipe_q[DSP_LATENCY-1];

  // Shift the fire tag so that it lines up with the DSP's valid Z.
  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = s_fire;
    for (int i = 1; i < DSP_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  // A fire consumes a credit and an accepted result returns one.
  always_comb begin
    credits_d = credits_q;
    case ({s_fire, m_fire})
      2'b10:   credits_d = credits_q - CNT_W'(1);
      2'b01:   credits_d = credits_q + CNT_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  // Result FIFO bookkeeping. Credits guarantee there is always room for a write.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = dsp_z;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (m_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, m_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // dsp_reset is held high through reset and drops on the first edge after release.
  always_comb begin
    dsp_reset_d = 1'b0;
  end

  // State registers. Reset discards everything in flight or buffered.
  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      vpipe_q     <= '0;
      credits_q   <= DEPTH_C;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dsp_reset_q <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vpipe_q     <= vpipe_d;
      credits_q   <= credits_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dsp_reset_q <= dsp_reset_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dsp_mult_issue_collect.sv
// Testbench for dsp_mult_issue_collect. It contains a two-stage DSP model
// (input register and output register) and a transaction-level reference that
// holds a queue of outstanding products, each with its visible-from cycle.
`timescale 1ns/1ps

module tb_dsp_mult_issue_collect;

   localparam int LAT     = 2;
   localparam int DEPTH   = 4;
   localparam int RES_LAT = LAT + 1;

   logic        clk = 1'b0;
   logic        lreset;
   logic        s_valid, s_ready;
   logic [19:0] s_a;
   logic [17:0] s_b;
   logic        s_unsigned_a, s_unsigned_b;
   logic [19:0] dsp_a;
   logic [17:0] dsp_b;
   logic        dsp_unsigned_a, dsp_unsigned_b;
   logic [2:0]  dsp_feedback;
   logic        dsp_reset;
   logic [37:0] dsp_z;
   logic        m_valid, m_ready;
   logic [37:0] m_z;
   logic        busy;

   int numChecks = 0;
   int numFails  = 0;

   typedef struct {
      longint      readyCyc;
      logic [37:0] z;
   } pend_t;

   pend_t  pendQ[$];
   longint cyc = 0;
   logic   expDspReset = 1'b1;

   logic        lastMValid, lastSReady;
   logic [37:0] lastMZ;

   typedef struct {
      logic [19:0] a;
      logic [17:0] b;
      logic        ua;
      logic        ub;
      logic [37:0] expZ;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   dsp_mult_issue_collect #(.DSP_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .lreset(lreset),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .s_unsigned_a(s_unsigned_a), .s_unsigned_b(s_unsigned_b),
      .dsp_a(dsp_a), .dsp_b(dsp_b),
      .dsp_unsigned_a(dsp_unsigned_a), .dsp_unsigned_b(dsp_unsigned_b),
      .dsp_feedback(dsp_feedback), .dsp_reset(dsp_reset), .dsp_z(dsp_z),
      .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z), .busy(busy)
   );

   // Reference multiply: extend each operand according to its flag, then multiply.
   function automatic logic [37:0] mulRef(logic [19:0] a, logic [17:0] b, logic ua, logic ub);
      longint sa, sb;
      sa = ua ? longint'(a) : longint'($signed(a));
      sb = ub ? longint'(b) : longint'($signed(b));
      return 38'(sa * sb);
   endfunction

   // DSP model. Both the input stage and the output stage are registered.
   logic [19:0] aR;
   logic [17:0] bR;
   logic        uaR, ubR;
   logic [37:0] zR;
   always @(posedge clk) begin
      aR  <= dsp_a;
      bR  <= dsp_b;
      uaR <= dsp_unsigned_a;
      ubR <= dsp_unsigned_b;
      zR  <= mulRef(aR, bR, uaR, ubR);
   end
   assign dsp_z = zR;

   function automatic logic expSReady();
      return lreset && !expDspReset && (pendQ.size() < DEPTH);
   endfunction

   function automatic logic expMValid();
      return (pendQ.size() > 0) && (pendQ[0].readyCyc <= cyc);
   endfunction

   task automatic checkEq(string name, logic [63:0] act, logic [63:0] exp);
      numChecks++;
      if (act !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare the DUT outputs against the reference in the current cycle.
   task automatic checkOutput();
      checkEq("s_ready", 64'(s_ready), 64'(expSReady()));
      checkEq("m_valid", 64'(m_valid), 64'(expMValid()));
      checkEq("busy", 64'(busy), 64'(pendQ.size() != 0));
      checkEq("dsp_reset", 64'(dsp_reset), 64'(expDspReset));
      checkEq("dsp_feedback", 64'(dsp_feedback), 64'(0));
      checkEq("dsp_a_pass", 64'(dsp_a), 64'(s_a));
      if (expMValid()) checkEq("m_z", 64'(m_z), 64'(pendQ[0].z));
      if (!lreset) checkEq("m_z_reset", 64'(m_z), 64'(0));
   endtask

   task automatic applyStimulus(logic v, logic mr, logic [19:0] a, logic [17:0] b, logic ua, logic ub);
      s_valid      = v;
      m_ready      = mr;
      s_a          = a;
      s_b          = b;
      s_unsigned_a = ua;
      s_unsigned_b = ub;
   endtask

   // Run one clock cycle: check at the negedge, then advance the reference at the posedge.
   task automatic stepCycle();
      logic sf, mf;
      logic [37:0] pz;
      @(negedge clk);
      checkOutput();
      lastMValid = m_valid;
      lastMZ     = m_z;
      lastSReady = s_ready;
      sf = s_valid && expSReady();
      mf = m_ready && expMValid();
      pz = mulRef(s_a, s_b, s_unsigned_a, s_unsigned_b);
      @(posedge clk);
      if (!lreset) begin
         pendQ.delete();
         expDspReset = 1'b1;
      end else begin
         if (mf) void'(pendQ.pop_front());
         if (sf) pendQ.push_back('{cyc + RES_LAT, pz});
         expDspReset = 1'b0;
      end
      cyc++;
      #1;
   endtask

   task automatic randOperands();
      applyStimulus(1'b1, m_ready, 20'($urandom), 18'($urandom),
                    1'($urandom), 1'($urandom));
   endtask

   // By construction the FIFO is never written while it is full.
   always @(negedge clk) begin
      if (lreset === 1'b1 && dut.vpipe_q[LAT-1] && dut.count_q == 3'(DEPTH)) begin
         numChecks++;
         numFails++;
         $display("[TB] FAIL fifo_overflow: write while count=%0d", dut.count_q);
      end
   end

   initial begin
      int fires, results, gotAt;
      vecs[0] = '{20'd3,     18'd5,     1'b1, 1'b1, 38'd15};
      vecs[1] = '{20'hFFFFE, 18'd7,     1'b0, 1'b0, 38'h3FFFFFFFF2};
      vecs[2] = '{20'hFFFFE, 18'd1,     1'b1, 1'b0, 38'h00000FFFFE};
      vecs[3] = '{20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 38'h3FFFEC0001};
      vecs[4] = '{20'h80000, 18'h20000, 1'b0, 1'b0, 38'h1000000000};
      vecs[5] = '{20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 38'd1};

      lreset = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      repeat (3) stepCycle();
      lreset = 1'b1;
      stepCycle();
      checkEq("s_ready_release_cycle", 64'(lastSReady), 64'(0));
      stepCycle();
      checkEq("s_ready_after_release", 64'(lastSReady), 64'(1));

      $display("[TB] Directed single-op vectors");
      for (int v = 0; v < 6; v++) begin
         applyStimulus(1'b1, 1'b1, vecs[v].a, vecs[v].b, vecs[v].ua, vecs[v].ub);
         stepCycle();
         s_valid = 1'b0;
         gotAt = -1;
         for (int k = 1; k <= 8; k++) begin
            stepCycle();
            if (lastMValid && gotAt < 0) begin
               gotAt = k;
               checkEq($sformatf("vec%0d_z", v), 64'(lastMZ), 64'(vecs[v].expZ));
            end
         end
         checkEq($sformatf("vec%0d_latency", v), 64'(gotAt), 64'(RES_LAT));
         checkEq($sformatf("vec%0d_idle", v), 64'(busy), 64'(0));
      end

      $display("[TB] Throughput burst");
      m_ready = 1'b1;
      fires = 0;
      results = 0;
      for (int k = 0; k < 16; k++) begin
         randOperands();
         stepCycle();
         if (lastSReady) fires++;
         if (lastMValid) results++;
      end
      s_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         stepCycle();
         if (lastMValid) results++;
      end
      checkEq("burst_fires", 64'(fires), 64'(16));
      checkEq("burst_results", 64'(results), 64'(16));

      $display("[TB] Backpressure");
      m_ready = 1'b0;
      fires = 0;
      for (int k = 0; k < 10; k++) begin
         randOperands();
         stepCycle();
         if (lastSReady) fires++;
      end
      checkEq("bp_fires", 64'(fires), 64'(DEPTH));
      checkEq("bp_s_ready_low", 64'(lastSReady), 64'(0));
      s_valid = 1'b0;
      m_ready = 1'b1;
      results = 0;
      for (int k = 0; k < 10; k++) begin
         stepCycle();
         if (lastMValid) results++;
      end
      checkEq("bp_results", 64'(results), 64'(DEPTH));

      $display("[TB] Simultaneous fire and accept at one credit");
      m_ready = 1'b0;
      for (int k = 0; k < DEPTH - 1; k++) begin
         randOperands();
         stepCycle();
      end
      s_valid = 1'b0;
      repeat (4) stepCycle();
      randOperands();
      m_ready = 1'b1;
      stepCycle();
      checkEq("sim_fire_ready", 64'(lastSReady), 64'(1));
      checkEq("sim_accept_valid", 64'(lastMValid), 64'(1));
      s_valid = 1'b0;
      m_ready = 1'b0;
      stepCycle();
      checkEq("sim_credit_kept", 64'(lastSReady), 64'(1));
      m_ready = 1'b1;
      repeat (8) stepCycle();

      $display("[TB] Mid-operation reset");
      m_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         randOperands();
         stepCycle();
      end
      s_valid = 1'b0;
      lreset = 1'b0;
      pendQ.delete();
      expDspReset = 1'b1;
      #1;
      checkEq("rst_m_valid", 64'(m_valid), 64'(0));
      checkEq("rst_busy", 64'(busy), 64'(0));
      checkEq("rst_dsp_reset", 64'(dsp_reset), 64'(1));
      checkEq("rst_s_ready", 64'(s_ready), 64'(0));
      repeat (2) stepCycle();
      lreset = 1'b1;
      m_ready = 1'b1;
      stepCycle();
      checkEq("rst_release_s_ready0", 64'(lastSReady), 64'(0));
      stepCycle();
      checkEq("rst_release_s_ready1", 64'(lastSReady), 64'(1));
      results = 0;
      for (int k = 0; k < 8; k++) begin
         stepCycle();
         if (lastMValid) results++;
      end
      checkEq("rst_no_stale", 64'(results), 64'(0));

      $display("[TB] Randomized traffic");
      for (int k = 0; k < 400; k++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       20'($urandom), 18'($urandom), 1'($urandom), 1'($urandom));
         stepCycle();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (10) stepCycle();
      checkEq("final_idle", 64'(busy), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
